// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Keeps the fetch PC, issues one instruction-memory request at a time and
// buffers returned words with their PCs in a 2-entry FIFO toward decode.
// Redirects flush the buffer and discard any in-flight response.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- when defined, a redirect
// to a non-word-aligned target raises misalign and halts requests until the
// next aligned redirect. When undefined the target's low two bits are
// ignored and misalign is tied low.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        misalign
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] req_pc_r;
    logic [31:0] data_mem_r [0:1];
    logic [31:0] pc_mem_r   [0:1];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  count_r;
    logic        fire_s;
    logic        push_s;
    logic        pop_s;
    logic        halt_s;
    logic [31:0] redir_target_s;

    // Redirect targets are always word aligned; the low bits only feed the misalign check.
    assign redir_target_s = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_r;

    // Misalign flag: set by an unaligned redirect, cleared by an aligned one.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            misalign_r <= 1'b0;
        end else if (redirect_valid) begin
            misalign_r <= (redirect_pc[1:0] != 2'b00);
        end else begin
            misalign_r <= misalign_r;
        end
    end

    assign halt_s   = misalign_r;
    assign misalign = misalign_r;
`else
    assign halt_s   = 1'b0;
    assign misalign = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state. A grant cannot coincide with a redirect in RUN because
    // the request is masked by redirect_valid, so RUN only ever goes to WAIT.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (fire_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_s = ST_RUN;
                end else if (redirect_valid) begin
                    state_s = ST_DROP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_RUN;
            end
        endcase
    end

    // FSM outputs and FIFO strobes. The request needs a free slot so the
    // returning word can always be pushed; a redirect overrides push and pop.
    always_comb begin
        imem_req = 1'b0;
        if (resetn && (state_r == ST_RUN) && (count_r != 2'd2) && !redirect_valid && !halt_s) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
        fire_s = imem_req && imem_gnt;
        push_s = (state_r == ST_WAIT) && imem_rvalid && !redirect_valid;
        pop_s  = (count_r != 2'd0) && inst_ready && !redirect_valid;
    end

    assign imem_addr = pc_r;

    // Fetch PC and the PC of the outstanding request.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc_r     <= RESET_PC;
            req_pc_r <= 32'h0000_0000;
        end else if (redirect_valid) begin
            pc_r     <= redir_target_s;
            req_pc_r <= req_pc_r;
        end else if (fire_s) begin
            pc_r     <= pc_r + 32'd4;
            req_pc_r <= pc_r;
        end else begin
            pc_r     <= pc_r;
            req_pc_r <= req_pc_r;
        end
    end

    // Two-entry instruction buffer; a redirect empties it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_mem_r[0] <= 32'h0000_0000;
            data_mem_r[1] <= 32'h0000_0000;
            pc_mem_r[0]   <= 32'h0000_0000;
            pc_mem_r[1]   <= 32'h0000_0000;
            rd_ptr_r      <= 1'b0;
            wr_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
        end else if (redirect_valid) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= imem_rdata;
                pc_mem_r[wr_ptr_r]   <= req_pc_r;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign inst_valid = (count_r != 2'd0);
    assign inst_data  = inst_valid ? data_mem_r[rd_ptr_r] : 32'h0000_0000;
    assign inst_pc    = inst_valid ? pc_mem_r[rd_ptr_r]   : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a queue-based
// reference model, plus hand-computed literal expectations.
module tb_fetch_unit;

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        misalign;

    fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .misalign       (misalign)
    );

    always #5 clock = ~clock;

    // Reference model: fetch PC, one outstanding request, discard flag, queue of {word, pc}.
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_busy;
    bit          m_drop;
    bit          m_mis;
    logic [63:0] m_q [$];

    // Bench memory responder for the free-running phase.
    bit auto_rsp;
    bit r_busy;
    int r_cnt;

    int n_chk;
    int n_pass;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc     = TB_RESET_PC;
        m_req_pc = 32'h0;
        m_busy   = 1'b0;
        m_drop   = 1'b0;
        m_mis    = 1'b0;
        m_q.delete();
        r_busy   = 1'b0;
        r_cnt    = 0;
    endtask

    function automatic bit exp_req();
        return resetn && !m_busy && (m_q.size() < 2) && !redirect_valid && !m_mis;
    endfunction

    task automatic compare_all();
        logic [63:0] head;
        chk1("imem_req", imem_req, exp_req());
        if (exp_req()) chk32("imem_addr", imem_addr, m_pc);
        chk1("inst_valid", inst_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            head = m_q[0];
            chk32("inst_data", inst_data, head[63:32]);
            chk32("inst_pc", inst_pc, head[31:0]);
        end
        chk1("misalign", misalign, m_mis);
    endtask

    task automatic model_edge(input bit fire);
        if (!resetn) begin
            model_reset();
        end else if (redirect_valid) begin
            m_q.delete();
            m_pc  = redirect_pc & 32'hFFFF_FFFC;
            m_mis = MIS_EN && (redirect_pc[1:0] != 2'b00);
            if (m_busy) begin
                if (imem_rvalid) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
        end else begin
            if (m_q.size() != 0 && inst_ready) void'(m_q.pop_front());
            if (m_busy && imem_rvalid) begin
                if (!m_drop) begin
                    if (m_q.size() >= 2) chk1("slot_reserved", 1'b0, 1'b1);
                    m_q.push_back({imem_rdata, m_req_pc});
                end
                m_busy = 1'b0;
                m_drop = 1'b0;
            end
            if (fire) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
                m_busy   = 1'b1;
            end
        end
    endtask

    task automatic responder_edge(input bit fire);
        if (imem_rvalid) r_busy = 1'b0;
        else if (r_busy && r_cnt > 0) r_cnt--;
        if (fire) begin
            r_busy = 1'b1;
            r_cnt  = int'($urandom_range(0, 2));
        end
    endtask

    task automatic set_in(input logic g, input logic rv, input logic [31:0] rd,
                          input logic rdr, input logic [31:0] rp, input logic rdy);
        imem_gnt       = g;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        redirect_valid = rdr;
        redirect_pc    = rp;
        inst_ready     = rdy;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // One clock: compare just before the rising edge, then advance the model.
    task automatic tick();
        bit fire;
        if (!resetn) model_reset();
        #1;
        compare_all();
        fire = exp_req() && imem_gnt;
        @(posedge clock);
        model_edge(fire);
        if (auto_rsp) responder_edge(fire);
        @(negedge clock);
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        auto_rsp = 1'b0;
        resetn   = 1'b0;
        model_reset();
        idle();
        #1;
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", inst_valid, 1'b0);
        chk32("rst_data", inst_data, 32'h0);
        chk32("rst_pc", inst_pc, 32'h0);
        chk1("rst_misalign", misalign, 1'b0);
        tick();
        tick();

        // First fetch: request right after reset, word returned one cycle after grant.
        resetn = 1'b1;
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("first_req", imem_req, 1'b1);
        chk32("first_addr", imem_addr, 32'h0000_0000);
        tick();
        set_in(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("lat_valid", inst_valid, 1'b1);
        chk32("lat_pc", inst_pc, 32'h0000_0000);
        chk32("lat_data", inst_data, 32'h0000_0013);
        chk32("next_addr", imem_addr, 32'h0000_0004);
        tick();

        // Backpressure: buffer fills with pc 0 and 4, then requests stop.
        set_in(1'b0, 1'b1, 32'h0010_0093, 1'b0, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            tick();
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        chk1("full_req", imem_req, 1'b0);
        chk32("full_head_pc", inst_pc, 32'h0000_0000);
        chk32("full_head_data", inst_data, 32'h0000_0013);
        tick();
        #1;
        chk32("second_pc", inst_pc, 32'h0000_0004);
        chk32("second_data", inst_data, 32'h0010_0093);
        tick();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("drained", inst_valid, 1'b0);
        chk32("drained_addr", imem_addr, 32'h0000_0008);
        tick();

        // Redirect while waiting: the late response is dropped.
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b0);
        tick();
        set_in(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("drop_req", imem_req, 1'b0);
        tick();
        idle();
        #1;
        chk1("drop_valid", inst_valid, 1'b0);
        chk1("drop_req_after", imem_req, 1'b1);
        chk32("drop_addr", imem_addr, 32'h0000_0100);
        tick();

        // Redirect together with rvalid: data discarded, buffered entry flushed.
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        set_in(1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 32'h0, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk32("pre_flush_pc", inst_pc, 32'h0000_0100);
        tick();
        set_in(1'b0, 1'b1, 32'hBBBB_0002, 1'b1, 32'h0000_0200, 1'b0);
        tick();
        idle();
        #1;
        chk1("flush_valid", inst_valid, 1'b0);
        chk1("flush_req", imem_req, 1'b1);
        chk32("flush_addr", imem_addr, 32'h0000_0200);
        tick();

        // PC wrap at the top of the address space.
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk32("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        set_in(1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
        tick();
        idle();
        #1;
        chk32("wrap_next", imem_addr, 32'h0000_0000);
        chk32("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk32("wrap_inst_data", inst_data, 32'h1234_5678);
        tick();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();

        // Unaligned redirect target.
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0102, 1'b0);
        tick();
        if (MIS_EN) begin
            set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            #1;
            chk1("mis_flag", misalign, 1'b1);
            chk1("mis_halt", imem_req, 1'b0);
            for (int i = 0; i < 3; i++) tick();
            set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b0);
            tick();
            idle();
            #1;
            chk1("mis_clear", misalign, 1'b0);
            chk1("mis_resume", imem_req, 1'b1);
            chk32("mis_addr", imem_addr, 32'h0000_0200);
            tick();
        end else begin
            idle();
            #1;
            chk1("nomis_flag", misalign, 1'b0);
            chk1("nomis_req", imem_req, 1'b1);
            chk32("nomis_addr", imem_addr, 32'h0000_0100);
            tick();
        end

        // Reset mid-transaction; a late response afterwards is ignored.
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        resetn = 1'b0;
        idle();
        tick();
        resetn = 1'b1;
        set_in(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("rst_mid_req", imem_req, 1'b1);
        chk32("rst_mid_addr", imem_addr, TB_RESET_PC);
        tick();
        idle();
        #1;
        chk1("rst_late_valid", inst_valid, 1'b0);
        tick();

        // Mixed traffic with a bench responder of 1-3 cycle latency.
        auto_rsp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 3) != 0),
                   (r_busy && r_cnt == 0),
                   $urandom,
                   ($urandom_range(0, 9) == 0),
                   ($urandom & 32'h0000_0FFF),
                   ($urandom_range(0, 3) != 0));
            tick();
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port imem_req  out  1  instruction memory request.
REQ-005 SHALL have port imem_addr  out  32  request address, word-aligned.
REQ-006 SHALL have port imem_gnt  in  1  request accepted this cycle.
REQ-007 SHALL have port imem_rvalid  in  1  read data valid, in order, at least 1 cycle after the grant.
REQ-008 SHALL have port imem_rdata  in  32  instruction word.
REQ-009 SHALL have port redirect_valid  in  1  branch/jump redirect strobe.
REQ-010 SHALL have port redirect_pc  in  32  redirect target.
REQ-011 SHALL have port inst_valid  out  1  buffer head valid toward decode/reg_file.
REQ-012 SHALL have port inst_ready  in  1  decode consumes the head.
REQ-013 SHALL have port inst_data  out  32  instruction at the head.
REQ-014 SHALL have port inst_pc  out  32  PC of inst_data.
REQ-015 SHALL have port misalign  out  1  misaligned redirect flag.

Function
REQ-016 SHALL hold a PC register, a 2-entry FIFO of {instr, pc}, and an FSM with states RUN, WAIT and DROP.
REQ-017 imem_req SHALL be 1 only when state=RUN, FIFO count<2, redirect_valid=0 and the fetch is not halted; imem_addr SHALL equal the PC.
REQ-018 imem_addr SHALL stay stable while imem_req=1 and imem_gnt=0.
REQ-019 On imem_req&&imem_gnt: PC<=PC+4 (mod 2^32, FFFF_FFFC wraps to 0000_0000); request PC latched; RUN->WAIT.
REQ-020 In WAIT, imem_rvalid SHALL push {imem_rdata, latched PC} into the FIFO; WAIT->RUN.
REQ-021 At most one request SHALL be outstanding; a slot SHALL be reserved for it, so a push never meets a full FIFO.
REQ-022 Latency SHALL be rvalid at cycle N -> inst_valid=1 with that word at cycle N+1.
REQ-023 inst_valid=(count!=0); inst_valid&&inst_ready SHALL pop the head; a simultaneous push and pop SHALL leave count unchanged.
REQ-024 inst_data and inst_pc SHALL hold while inst_valid=1 and inst_ready=0.
REQ-025 redirect_valid SHALL flush the FIFO (count<=0) and set PC<=redirect_pc, with priority over any push or pop that cycle.
REQ-026 Redirect in WAIT, or in the same cycle as a grant, SHALL go to DROP; the next rvalid SHALL be discarded and the FSM SHALL go DROP->RUN.
REQ-027 Redirect in the same cycle as an rvalid in WAIT SHALL discard that data and go to RUN.
REQ-028 Redirect in DROP SHALL stay in DROP, still discarding one response.

Reset
REQ-029 While resetn=0: PC=RESET_PC, state=RUN, count=0, imem_req=0, inst_valid=0, inst_data=0, inst_pc=0, misalign=0.
REQ-030 The first request SHALL be raised in the first cycle after resetn rises.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request; a late rvalid after reset SHALL be ignored (state RUN).

Configuration
REQ-032 With macro FETCH_MISALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0]!=0 SHALL set misalign=1 and halt requests; misalign SHALL clear and fetch SHALL resume on the next aligned redirect.
REQ-033 Without FETCH_MISALIGN_CHECK_EN: redirect_pc[1:0] SHALL be forced to 00 and misalign SHALL be tied to 0.

Verification
REQ-034 Reset release, gnt same cycle, rvalid 1 cycle later with 32'h00000013 -> inst_valid with inst_pc=0; next imem_addr=4.
REQ-035 inst_ready=0 for 10 cycles -> exactly 2 entries (pc 0, 4) buffered, imem_req=0, head held stable.
REQ-036 Redirect to 32'h100 while WAIT -> next rvalid dropped, inst_valid=0, next imem_addr=32'h100.
REQ-037 Redirect in the same cycle as rvalid -> data discarded; the FIFO holds no stale entry.
REQ-038 PC=32'hFFFF_FFFC granted -> next imem_addr=0.
REQ-039 Macro on, redirect_pc=32'h102 -> misalign=1, no imem_req until redirect 32'h200; macro off -> fetch from 32'h100.
